// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Write-side controller for the FIFO memory. NREQ requesters share the single
//   memory write port through round-robin arbitration with a bounded burst lock.
//   The block owns the binary/Gray write pointer and derives w_full from the
//   read pointer, which has already been synchronised into w_clk.
//
// Handshake: a word moves from requester i when req_valid[i] && req_ready[i]
//   in the same w_clk cycle. A requester keeps req_data stable while it is
//   valid and not ready. The memory captures w_data at w_addr on the same edge
//   that w_inc is high, so the write latency is zero cycles.
//
// Ports
//   w_clk, w_rst_n  write clock, asynchronous active-low reset
//   req_valid       per-requester word available
//   req_data        requester i data in bits [i*DATA_W +: DATA_W]
//   req_ready       per-requester accept, at most one bit set
//   rq2_gray_ptr    read pointer (Gray), synchronised to w_clk
//   w_data/w_inc    memory write data and strobe
//   w_full          FIFO full (registered)
//   w_addr          memory write address (low bits of the binary pointer)
//   w_gray_ptr      write pointer (Gray, registered), for read-domain sync
//   grant_id        requester granted now, or the last one granted
//   fsm_state       debug view of the arbiter FSM (0 = IDLE, 1 = LOCK)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int PTR_W  = 4,
   parameter int NREQ   = 2,
   parameter int BURST  = 2
) (
   input  logic                     w_clk,
   input  logic                     w_rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic [PTR_W-1:0]         rq2_gray_ptr,
   output logic [DATA_W-1:0]        w_data,
   output logic                     w_inc,
   output logic                     w_full,
   output logic [PTR_W-2:0]         w_addr,
   output logic [PTR_W-1:0]         w_gray_ptr,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     fsm_state
);

   localparam int ID_W = $clog2(NREQ);
   localparam int BCW  = $clog2(BURST + 1);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t            state;
   logic [PTR_W-1:0]  wptr_bin;
   logic [ID_W-1:0]   last_id;     // owner of the current/last burst
   logic [ID_W-1:0]   last_grant;  // shown on grant_id while nobody is granted
   logic [BCW-1:0]    burst_cnt;

   logic              grant_valid;
   logic [ID_W-1:0]   gnt;
   int                search_idx;
   logic              transfer;
   logic [PTR_W-1:0]  bin_next;
   logic [PTR_W-1:0]  gray_next;
   logic [PTR_W-1:0]  full_target;

   // Grant selection. The lock holder keeps the port while it still has data
   // and has not used up its burst; otherwise search round-robin starting just
   // after last_id, so last_id itself is considered last.
   always_comb begin
      grant_valid = 1'b0;
      gnt         = '0;
      search_idx  = 0;
      if (state == LOCK && req_valid[last_id] && burst_cnt < BCW'(BURST)) begin
         grant_valid = 1'b1;
         gnt         = last_id;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            search_idx = (int'(last_id) + k) % NREQ;
            if (!grant_valid && req_valid[search_idx]) begin
               grant_valid = 1'b1;
               gnt         = ID_W'(search_idx);
            end
         end
      end
   end

   // At most one ready bit, and none while the FIFO is full.
   always_comb begin
      req_ready = '0;
      if (grant_valid && !w_full) req_ready[gnt] = 1'b1;
   end

   assign transfer = |req_ready;
   assign w_inc    = transfer;
   assign w_data   = grant_valid ? req_data[gnt*DATA_W +: DATA_W] : '0;
   assign grant_id = grant_valid ? gnt : last_grant;

   // Full compares the pointer as it will be after this cycle's write against
   // the read pointer advanced by one full lap (top two Gray bits inverted).
   assign bin_next    = wptr_bin + {{(PTR_W-1){1'b0}}, transfer};
   assign gray_next   = bin_next ^ (bin_next >> 1);
   assign full_target = {~rq2_gray_ptr[PTR_W-1:PTR_W-2], rq2_gray_ptr[PTR_W-3:0]};

   assign w_addr    = wptr_bin[PTR_W-2:0];
   assign fsm_state = (state == LOCK);

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state      <= IDLE;
         wptr_bin   <= '0;
         w_gray_ptr <= '0;
         w_full     <= 1'b0;
         last_id    <= ID_W'(NREQ - 1);
         last_grant <= '0;
         burst_cnt  <= '0;
      end else begin
         wptr_bin   <= bin_next;
         w_gray_ptr <= gray_next;
         w_full     <= (gray_next == full_target);
         if (transfer) last_grant <= gnt;

         case (state)
            IDLE: begin
               if (transfer) begin
                  state     <= LOCK;
                  last_id   <= gnt;
                  burst_cnt <= BCW'(1);
               end
            end
            LOCK: begin
               if (!transfer) begin
                  // last_id is kept so the next search still starts after it
                  state     <= IDLE;
                  burst_cnt <= '0;
               end else if (gnt == last_id) begin
                  // A lone requester may keep winning the search; saturate.
                  if (burst_cnt < BCW'(BURST)) burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  last_id   <= gnt;
                  burst_cnt <= BCW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (DATA_W=8, PTR_W=4, NREQ=2, BURST=2).
//   Each requester is modelled by a word queue; a driver process presents the
//   head of each queue and pops it after an accepted transfer. Every expected
//   write {grant_id, w_data, w_addr, w_gray_ptr-before-write} is pushed into
//   exp_q by the test sequence and popped by a monitor on every w_inc.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int EXP_W = 16;

   logic        w_clk;
   logic        w_rst_n;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;
   logic [3:0]  rq2_gray_ptr;
   logic [7:0]  w_data;
   logic        w_inc;
   logic        w_full;
   logic [2:0]  w_addr;
   logic [3:0]  w_gray_ptr;
   logic [0:0]  grant_id;
   logic        fsm_state;

   logic [7:0]       src_q0[$];
   logic [7:0]       src_q1[$];
   logic [EXP_W-1:0] exp_q[$];
   logic             track_rq2;
   int               n_tests;
   int               n_fail;

   // Gray codes of 0..9, worked out by hand
   logic [3:0] gray_tab [0:9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

   fifo_wr_arbiter #(.DATA_W(8), .PTR_W(4), .NREQ(2), .BURST(2)) dut (
      .w_clk        (w_clk),
      .w_rst_n      (w_rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rq2_gray_ptr (rq2_gray_ptr),
      .w_data       (w_data),
      .w_inc        (w_inc),
      .w_full       (w_full),
      .w_addr       (w_addr),
      .w_gray_ptr   (w_gray_ptr),
      .grant_id     (grant_id),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] pack_exp(input logic id, input logic [7:0] d,
                                                 input logic [2:0] a, input logic [3:0] g);
      return {id, d, a, g};
   endfunction

   // Waits until both source queues reach the given sizes, bounded by budget.
   task automatic wait_q(input int t0, input int t1, input int budget,
                         input string name, output int cycles);
      cycles = 0;
      while ((src_q0.size() != t0 || src_q1.size() != t1) && cycles < budget) begin
         @(posedge w_clk);
         #2;
         cycles++;
      end
      check(name, ((src_q0.size() == t0) && (src_q1.size() == t1)) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      track_rq2    = 1'b0;
      src_q0.delete();
      src_q1.delete();
      req_valid    = '0;
      req_data     = '0;
      rq2_gray_ptr = '0;
      @(negedge w_clk);
      w_rst_n = 1'b0;
      repeat (2) @(negedge w_clk);
      w_rst_n = 1'b1;
      @(negedge w_clk);
   endtask

   // ---------------- requester driver ----------------
   initial begin : req_driver
      logic [1:0] fire;
      forever begin
         @(negedge w_clk);
         fire = req_valid & req_ready;
         @(posedge w_clk);
         #1;
         if (fire[0] && src_q0.size() > 0) void'(src_q0.pop_front());
         if (fire[1] && src_q1.size() > 0) void'(src_q1.pop_front());
         req_valid      = {src_q1.size() > 0, src_q0.size() > 0};
         req_data[7:0]  = (src_q0.size() > 0) ? src_q0[0] : 8'h00;
         req_data[15:8] = (src_q1.size() > 0) ? src_q1[0] : 8'h00;
         if (track_rq2) rq2_gray_ptr = w_gray_ptr;
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge w_clk) begin
      logic [EXP_W-1:0] e;
      if (w_rst_n && w_inc) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: actual id=%0d data=%0h addr=%0d required no write",
                     grant_id, w_data, w_addr);
         end else begin
            e = exp_q.pop_front();
            check("write_beat", {16'h0, grant_id, w_data, w_addr, w_gray_ptr}, {16'h0, e});
            check("ready_onehot", {30'h0, req_ready}, 32'h1 << e[15]);
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin : test_seq
      int cyc;
      n_tests      = 0;
      n_fail       = 0;
      track_rq2    = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      rq2_gray_ptr = '0;
      w_rst_n      = 1'b0;

      // Reset values
      #1;
      check("rst_w_full", w_full, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_w_gray", w_gray_ptr, 0);
      check("rst_w_inc", w_inc, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_fsm", fsm_state, 0);
      repeat (2) @(negedge w_clk);
      w_rst_n = 1'b1;
      @(negedge w_clk);

      // Single requester, three words
      src_q0.push_back(8'hA1);
      src_q0.push_back(8'hA2);
      src_q0.push_back(8'hA3);
      exp_q.push_back(pack_exp(1'b0, 8'hA1, 3'd0, 4'b0000));
      exp_q.push_back(pack_exp(1'b0, 8'hA2, 3'd1, 4'b0001));
      exp_q.push_back(pack_exp(1'b0, 8'hA3, 3'd2, 4'b0011));
      wait_q(0, 0, 20, "t1_drain", cyc);
      repeat (2) @(negedge w_clk);
      check("t1_gray_after", w_gray_ptr, 4'b0010);
      check("t1_addr_after", w_addr, 3);
      check("t1_idle", fsm_state, 0);
      check("t1_sb_empty", exp_q.size(), 0);

      // Both requesters, burst-of-two round robin: 0,0,1,1,0,0,1,1
      do_reset();
      track_rq2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src_q0.push_back(8'hB0 + 8'(i));
         src_q1.push_back(8'hC0 + 8'(i));
      end
      exp_q.push_back(pack_exp(1'b0, 8'hB0, 3'd0, gray_tab[0]));
      exp_q.push_back(pack_exp(1'b0, 8'hB1, 3'd1, gray_tab[1]));
      exp_q.push_back(pack_exp(1'b1, 8'hC0, 3'd2, gray_tab[2]));
      exp_q.push_back(pack_exp(1'b1, 8'hC1, 3'd3, gray_tab[3]));
      exp_q.push_back(pack_exp(1'b0, 8'hB2, 3'd4, gray_tab[4]));
      exp_q.push_back(pack_exp(1'b0, 8'hB3, 3'd5, gray_tab[5]));
      exp_q.push_back(pack_exp(1'b1, 8'hC2, 3'd6, gray_tab[6]));
      exp_q.push_back(pack_exp(1'b1, 8'hC3, 3'd7, gray_tab[7]));
      wait_q(0, 0, 40, "t2_drain", cyc);
      check("t2_cycles", cyc, 9);
      repeat (2) @(negedge w_clk);
      check("t2_no_full", w_full, 0);
      check("t2_sb_empty", exp_q.size(), 0);

      // Fill to full with the read pointer parked at 0, then release one slot
      do_reset();
      for (int i = 0; i < 9; i++) begin
         src_q0.push_back(8'hD0 + 8'(i));
         exp_q.push_back(pack_exp(1'b0, 8'hD0 + 8'(i), 3'(i), gray_tab[i]));
      end
      wait_q(1, 0, 40, "t3_fill", cyc);
      @(negedge w_clk);
      check("t3_full_set", w_full, 1);
      check("t3_ready_low", req_ready, 0);
      check("t3_inc_low", w_inc, 0);
      check("t3_addr_hold", w_addr, 0);
      check("t3_gray_full", w_gray_ptr, 4'b1100);
      repeat (3) @(negedge w_clk);
      check("t3_still_full", w_full, 1);
      check("t3_q_held", src_q0.size(), 1);
      @(posedge w_clk);
      #1;
      rq2_gray_ptr = 4'b0001;
      @(negedge w_clk);
      check("t3_full_lag", w_full, 1);
      @(negedge w_clk);
      check("t3_full_clear", w_full, 0);
      wait_q(0, 0, 10, "t3_drain", cyc);
      repeat (2) @(negedge w_clk);
      check("t3_gray_after", w_gray_ptr, 4'b1101);
      check("t3_addr_after", w_addr, 1);
      check("t3_sb_empty", exp_q.size(), 0);

      // Lock owner drops after one beat; the waiting requester goes next cycle
      do_reset();
      src_q0.push_back(8'hE0);
      src_q1.push_back(8'hF0);
      exp_q.push_back(pack_exp(1'b0, 8'hE0, 3'd0, 4'b0000));
      exp_q.push_back(pack_exp(1'b1, 8'hF0, 3'd1, 4'b0001));
      wait_q(0, 0, 20, "t4_drain", cyc);
      check("t4_back_to_back", cyc, 3);
      check("t4_sb_empty", exp_q.size(), 0);

      // Reset in the middle of a burst (burst_cnt = 1)
      do_reset();
      src_q0.push_back(8'h61);
      src_q0.push_back(8'h62);
      src_q0.push_back(8'h63);
      exp_q.push_back(pack_exp(1'b0, 8'h61, 3'd0, 4'b0000));
      wait_q(2, 0, 20, "t5_first_beat", cyc);
      check("t5_pre_addr", w_addr, 1);
      w_rst_n = 1'b0;
      src_q0.delete();
      req_valid = '0;
      req_data  = '0;
      #1;
      check("t5_rst_full", w_full, 0);
      check("t5_rst_addr", w_addr, 0);
      check("t5_rst_gray", w_gray_ptr, 0);
      check("t5_rst_inc", w_inc, 0);
      check("t5_rst_grant", grant_id, 0);
      check("t5_rst_fsm", fsm_state, 0);
      repeat (2) @(negedge w_clk);
      w_rst_n = 1'b1;
      @(negedge w_clk);
      src_q0.push_back(8'h71);
      src_q1.push_back(8'h81);
      exp_q.push_back(pack_exp(1'b0, 8'h71, 3'd0, 4'b0000));
      exp_q.push_back(pack_exp(1'b1, 8'h81, 3'd1, 4'b0001));
      wait_q(0, 0, 20, "t5_restart", cyc);
      repeat (2) @(negedge w_clk);
      check("t5_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
